// File: rtl/shm_move_engine_pkg.sv
// Shared types and helpers for the shared-memory move engine.
//   move_state_t : command FSM states
//   DST_INBUF/DST_WBUF : destination buffer indices
//   row_width()  : row width in bits (lanes * bits per lane)
//   sel_width()  : width of a destination-select field (never 0)
package shm_move_engine_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } move_state_t;

  localparam int unsigned DST_INBUF = 0;
  localparam int unsigned DST_WBUF  = 1;

  function automatic int unsigned row_width(input int unsigned lanes, input int unsigned data_w);
    return lanes * data_w;
  endfunction

  function automatic int unsigned sel_width(input int unsigned num_dst);
    return (num_dst > 1) ? 32'($clog2(num_dst)) : 32'd1;
  endfunction

endpackage

// File: rtl/shm_move_engine_rd_lat_pipe.sv
// Read-latency pipeline: carries {valid, destination address} alongside an
// outstanding shared-memory read so both emerge when the read data arrives.
//   i_clk, i_rst_n   : clock, async active-low clear
//   i_valid, i_addr  : read issued this cycle and its destination row
//   o_valid, o_addr  : same, delayed by RD_LAT cycles
module shm_move_engine_rd_lat_pipe #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr
);

  logic [RD_LAT-1:0] r_valid;
  logic [ADDR_W-1:0] r_addr [RD_LAT];

  // Shift register; a clear drops every in-flight entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < RD_LAT; i++) r_addr[i] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_addr[0]  <= i_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_addr[i]  <= r_addr[i-1];
      end
    end
  end

  assign o_valid = r_valid[RD_LAT-1];
  assign o_addr  = r_addr[RD_LAT-1];

endmodule

// File: rtl/shm_move_engine.sv
// Multi-row move engine: reads LEN strided rows from shared memory and writes
// them to consecutive rows of one destination buffer.
//   i_clk, i_rst_n             : clock, async active-low reset
//   i_start + command fields   : command strobe (IDLE only) and its operands
//   o_busy, o_done, o_err      : command status; done/err are one-cycle pulses
//   o_shm_ren, o_shm_a, i_shm_q: shared-memory read port (data RD_LAT later)
//   o_dst_wen, o_dst_a, o_dst_d: one-hot destination write port
module shm_move_engine
  import shm_move_engine_pkg::*;
#(
  parameter int unsigned LANES   = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned LEN_W   = 6,
  parameter int unsigned NUM_DST = 2,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_start,
  input  logic [ADDR_W-1:0]                    i_src_base,
  input  logic [ADDR_W-1:0]                    i_src_stride,
  input  logic [sel_width(NUM_DST)-1:0]        i_dst_sel,
  input  logic [ADDR_W-1:0]                    i_dst_base,
  input  logic [LEN_W-1:0]                     i_len,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err,
  output logic                                 o_shm_ren,
  output logic [ADDR_W-1:0]                    o_shm_a,
  input  logic [row_width(LANES, DATA_W)-1:0]  i_shm_q,
  output logic [NUM_DST-1:0]                   o_dst_wen,
  output logic [ADDR_W-1:0]                    o_dst_a,
  output logic [row_width(LANES, DATA_W)-1:0]  o_dst_d
);

  localparam int unsigned SEL_W = sel_width(NUM_DST);
  localparam int unsigned CNT_W = LEN_W + 1;

  move_state_t       r_state, w_state_nxt;
  logic              r_start_q;
  logic [ADDR_W-1:0] r_src_stride;
  logic [SEL_W-1:0]  r_dst_sel;
  logic [LEN_W-1:0]  r_len;
  logic              r_bad;
  logic [CNT_W-1:0]  r_iss_cnt, r_wr_cnt, w_wr_cnt_nxt;
  logic              r_shm_ren;
  logic [ADDR_W-1:0] r_shm_a, r_iss_dst;
  logic              r_busy, r_done, r_err;
  logic              w_start_go, w_cmd_bad, w_cmd_noop, w_issue_more;
  logic              w_issue_first, w_issue_next, w_busy_d, w_done_d, w_err_d;
  logic              w_pipe_valid;
  logic [ADDR_W-1:0] w_pipe_addr;

  // Rising-edge start: a strobe held high across a whole command launches it once.
  assign w_start_go   = i_start && !r_start_q;
  assign w_cmd_bad    = 32'(i_dst_sel) >= NUM_DST;
  assign w_cmd_noop   = w_cmd_bad || (i_len == '0);
  assign w_issue_more = r_iss_cnt < {1'b0, r_len};
  assign w_wr_cnt_nxt = r_wr_cnt + CNT_W'(w_pipe_valid);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state. No-op and invalid commands pass through DRAIN with a zero
  // length, which gives them the same two-cycle start-to-done latency.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_start_go) w_state_nxt = w_cmd_noop ? DRAIN : ISSUE;
      ISSUE:   if (!w_issue_more) w_state_nxt = DRAIN;
      DRAIN:   if (w_wr_cnt_nxt == {1'b0, r_len}) w_state_nxt = FINISH;
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode; registered below so status lines follow the state directly.
  always_comb begin
    w_issue_first = 1'b0;
    w_issue_next  = 1'b0;
    w_busy_d      = 1'b0;
    w_done_d      = 1'b0;
    w_err_d       = 1'b0;
    w_issue_first = (r_state == IDLE) && w_start_go && !w_cmd_noop;
    w_issue_next  = (r_state == ISSUE) && w_issue_more;
    w_busy_d      = (w_state_nxt != IDLE);
    w_done_d      = (w_state_nxt == FINISH);
    w_err_d       = w_done_d && r_bad;
  end

  // Command latch and status registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_start_q    <= 1'b0;
      r_src_stride <= '0;
      r_dst_sel    <= '0;
      r_len        <= '0;
      r_bad        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_start_q <= i_start;
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
      r_err     <= w_err_d;
      if ((r_state == IDLE) && w_start_go) begin
        r_src_stride <= i_src_stride;
        r_dst_sel    <= i_dst_sel;
        r_len        <= w_cmd_bad ? '0 : i_len;
        r_bad        <= w_cmd_bad;
      end
    end
  end

  // Read issue and write counting; addresses wrap modulo 2^ADDR_W.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shm_ren <= 1'b0;
      r_shm_a   <= '0;
      r_iss_dst <= '0;
      r_iss_cnt <= '0;
      r_wr_cnt  <= '0;
    end else begin
      if (w_issue_first) begin
        r_shm_ren <= 1'b1;
        r_shm_a   <= i_src_base;
        r_iss_dst <= i_dst_base;
        r_iss_cnt <= CNT_W'(1);
      end else if (w_issue_next) begin
        r_shm_ren <= 1'b1;
        r_shm_a   <= r_shm_a + r_src_stride;
        r_iss_dst <= r_iss_dst + ADDR_W'(1);
        r_iss_cnt <= r_iss_cnt + CNT_W'(1);
      end else begin
        r_shm_ren <= 1'b0;
        r_shm_a   <= '0;
      end
      if (r_state == IDLE)   r_wr_cnt <= '0;
      else if (w_pipe_valid) r_wr_cnt <= w_wr_cnt_nxt;
    end
  end

  shm_move_engine_rd_lat_pipe #(
    .RD_LAT (RD_LAT),
    .ADDR_W (ADDR_W)
  ) u_rd_lat_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (r_shm_ren),
    .i_addr  (r_iss_dst),
    .o_valid (w_pipe_valid),
    .o_addr  (w_pipe_addr)
  );

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_err     = r_err;
  assign o_shm_ren = r_shm_ren;
  assign o_shm_a   = r_shm_a;
  // Write port is driven straight from the returning read data.
  assign o_dst_wen = w_pipe_valid ? (NUM_DST'(1) << r_dst_sel) : '0;
  assign o_dst_a   = w_pipe_valid ? w_pipe_addr : '0;
  assign o_dst_d   = w_pipe_valid ? i_shm_q : '0;

endmodule

// File: tb/tb_shm_move_engine.sv
// Bench for shm_move_engine: two instances (RD_LAT=1/NUM_DST=2 and
// RD_LAT=3/NUM_DST=3) receive the same commands; expected reads, writes and
// done pulses are queued per instance at start and popped by a monitor.
module tb_shm_move_engine;
  import shm_move_engine_pkg::*;

  typedef struct { int cyc; logic [5:0] a; } rd_e_t;
  typedef struct { int cyc; logic [2:0] wen; logic [5:0] a; logic [127:0] d; } wr_e_t;
  typedef struct { int cyc; logic err; } dn_e_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [5:0] src = '0, stride = '0, dst = '0, len = '0;
  logic [1:0] sel = '0;

  logic busy0, done0, err0, ren0, busy1, done1, err1, ren1;
  logic [5:0] sa0, da0, sa1, da1;
  logic [1:0] wen0;
  logic [2:0] wen1;
  logic [127:0] dd0, dd1, q0 = '0, q1 = '0, p1a = '0, p1b = '0;

  int cyc = 0, checks = 0, errors = 0;
  rd_e_t q_rd[2][$];
  wr_e_t q_wr[2][$];
  dn_e_t q_dn[2][$];
  bit    pend_low[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shm_move_engine #(.LANES(4), .DATA_W(32), .ADDR_W(6), .LEN_W(6), .NUM_DST(2), .RD_LAT(1)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_src_base(src), .i_src_stride(stride),
    .i_dst_sel(sel[0]), .i_dst_base(dst), .i_len(len), .o_busy(busy0), .o_done(done0),
    .o_err(err0), .o_shm_ren(ren0), .o_shm_a(sa0), .i_shm_q(q0), .o_dst_wen(wen0),
    .o_dst_a(da0), .o_dst_d(dd0));

  shm_move_engine #(.LANES(4), .DATA_W(32), .ADDR_W(6), .LEN_W(6), .NUM_DST(3), .RD_LAT(3)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_src_base(src), .i_src_stride(stride),
    .i_dst_sel(sel), .i_dst_base(dst), .i_len(len), .o_busy(busy1), .o_done(done1),
    .o_err(err1), .o_shm_ren(ren1), .o_shm_a(sa1), .i_shm_q(q1), .o_dst_wen(wen1),
    .o_dst_a(da1), .o_dst_d(dd1));

  // Shared-memory contents: every lane tagged with its row address.
  function automatic logic [127:0] row_of(input logic [5:0] a);
    return {24'hA0B0C3, 2'b00, a, 24'hA1B1C2, 2'b00, a, 24'hA2B2C1, 2'b00, a, 24'hA3B3C0, 2'b00, a};
  endfunction

  // Shared-memory models with latency 1 and 3.
  always @(posedge clk) begin
    q0  <= ren0 ? row_of(sa0) : '0;
    p1a <= ren1 ? row_of(sa1) : '0;
    p1b <= p1a;
    q1  <= p1b;
  end

  task automatic expect_cmd(input int d, input int t, input int s, input int st, input int sl,
                            input int db, input int n);
    int lat = (d == 0) ? 1 : 3;
    int nd  = (d == 0) ? 2 : 3;
    int se  = (d == 0) ? (sl % 2) : sl;
    bit bad = (se >= nd);
    if (n == 0 || bad) begin
      q_dn[d].push_back('{t + 2, bad});
    end else begin
      for (int k = 0; k < n; k++) begin
        q_rd[d].push_back('{t + 1 + k, 6'(s + k * st)});
        q_wr[d].push_back('{t + 1 + lat + k, 3'(1 << se), 6'(db + k), row_of(6'(s + k * st))});
      end
      q_dn[d].push_back('{t + n + lat + 1, 1'b0});
    end
  endtask

  task automatic check_dut(input int d, input logic ren, input logic [5:0] sa, input logic [2:0] wen,
                           input logic [5:0] da, input logic [127:0] dd, input logic dn,
                           input logic er, input logic bsy);
    rd_e_t r;
    wr_e_t w;
    dn_e_t e;
    if (pend_low[d]) begin
      checks++;
      pend_low[d] = 1'b0;
      if (bsy !== 1'b0) begin
        errors++;
        $display("FAIL busy_fall dut%0d cyc=%0d got busy=%b want 0", d, cyc, bsy);
      end
    end
    if (ren !== 1'b0) begin
      checks++;
      if (q_rd[d].size() == 0) begin
        errors++;
        $display("FAIL rd dut%0d unexpected read cyc=%0d a=%0d want none", d, cyc, sa);
      end else begin
        r = q_rd[d].pop_front();
        if (r.cyc != cyc || r.a !== sa) begin
          errors++;
          $display("FAIL rd dut%0d got cyc=%0d a=%0d want cyc=%0d a=%0d", d, cyc, sa, r.cyc, r.a);
        end
      end
    end
    if (wen !== 3'b000) begin
      checks++;
      if (q_wr[d].size() == 0) begin
        errors++;
        $display("FAIL wr dut%0d unexpected write cyc=%0d wen=%b a=%0d want none", d, cyc, wen, da);
      end else begin
        w = q_wr[d].pop_front();
        if (w.cyc != cyc || w.wen !== wen || w.a !== da || w.d !== dd) begin
          errors++;
          $display("FAIL wr dut%0d got cyc=%0d wen=%b a=%0d d=%h want cyc=%0d wen=%b a=%0d d=%h",
                   d, cyc, wen, da, dd, w.cyc, w.wen, w.a, w.d);
        end
      end
    end
    if (dn !== 1'b0) begin
      checks++;
      if (q_dn[d].size() == 0) begin
        errors++;
        $display("FAIL done dut%0d unexpected done cyc=%0d want none", d, cyc);
      end else begin
        e = q_dn[d].pop_front();
        if (e.cyc != cyc || e.err !== er || bsy !== 1'b1) begin
          errors++;
          $display("FAIL done dut%0d got cyc=%0d err=%b busy=%b want cyc=%0d err=%b busy=1",
                   d, cyc, er, bsy, e.cyc, e.err);
        end
        pend_low[d] = 1'b1;
      end
    end
  endtask

  // Monitor: pops the scoreboards whenever an instance shows activity.
  always @(negedge clk) begin
    if (rst_n) begin
      check_dut(0, ren0, sa0, {1'b0, wen0}, da0, dd0, done0, err0, busy0);
      check_dut(1, ren1, sa1, wen1, da1, dd1, done1, err1, busy1);
    end
  end

  function automatic bit sb_empty();
    return q_rd[0].size() == 0 && q_wr[0].size() == 0 && q_dn[0].size() == 0 &&
           q_rd[1].size() == 0 && q_wr[1].size() == 0 && q_dn[1].size() == 0 &&
           !pend_low[0] && !pend_low[1];
  endfunction

  task automatic flush();
    for (int d = 0; d < 2; d++) begin
      q_rd[d].delete();
      q_wr[d].delete();
      q_dn[d].delete();
      pend_low[d] = 1'b0;
    end
  endtask

  task automatic send(input int s, input int st, input int sl, input int db, input int n, input int hold);
    int t;
    @(posedge clk); #1;
    src = 6'(s); stride = 6'(st); sel = 2'(sl); dst = 6'(db); len = 6'(n); start = 1'b1;
    t = cyc;
    expect_cmd(0, t, s, st, sl, db, n);
    expect_cmd(1, t, s, st, sl, db, n);
    repeat (hold) @(posedge clk);
    #1;
    start = 1'b0;
    src = 6'h2B; stride = 6'h15; sel = 2'b11; dst = 6'h3C; len = 6'h3F;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    bit ok = 1'b0;
    while (n < 300 && !ok) begin
      @(negedge clk); #1;
      ok = sb_empty() && busy0 === 1'b0 && busy1 === 1'b0;
      n++;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s timeout: pending rd=%0d/%0d wr=%0d/%0d done=%0d/%0d busy=%b/%b want all 0",
               tag, q_rd[0].size(), q_rd[1].size(), q_wr[0].size(), q_wr[1].size(),
               q_dn[0].size(), q_dn[1].size(), busy0, busy1);
      flush();
    end
  endtask

  task automatic check_quiet(input string tag);
    checks++;
    if ({busy0, done0, err0, ren0, sa0, wen0, da0} !== '0 || dd0 !== '0 ||
        {busy1, done1, err1, ren1, sa1, wen1, da1} !== '0 || dd1 !== '0) begin
      errors++;
      $display("FAIL %s outputs got ctl0=%h d0=%h ctl1=%h d1=%h want all 0", tag,
               {busy0, done0, err0, ren0, sa0, wen0, da0}, dd0,
               {busy1, done1, err1, ren1, sa1, wen1, da1}, dd1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    #1;
    check_quiet("reset_state");
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset_hold");
    rst_n = 1'b1;

    send(10, 2, int'(DST_WBUF), 20, 3, 1);   wait_idle("basic");
    send(62, 1, int'(DST_INBUF), 63, 3, 1);  wait_idle("wrap");
    send(2, 63, 1, 5, 3, 1);                 wait_idle("neg_stride");
    send(4, 1, 2, 9, 0, 1);                  wait_idle("len0_sel2");
    send(12, 5, 3, 50, 2, 1);                wait_idle("sel3");
    send(5, 3, 0, 40, 4, 10);                wait_idle("start_held");
    send(33, 0, 1, 8, 4, 1);                 wait_idle("stride0");
    send(0, 1, 0, 0, 63, 1);                 wait_idle("len_max");

    // Reset during dut0's second write cycle; in-flight work must vanish.
    send(7, 1, 0, 30, 5, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    flush();
    #1;
    check_quiet("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    check_quiet("mid_reset_hold");
    rst_n = 1'b1;
    send(20, 4, 1, 11, 2, 1);                wait_idle("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
